// File: rtl/pid_pwm_actuator.sv
// PWM actuator for the PID loop: one-entry command register, period-boundary
// duty updates with slew limiting, and a controlled ramp-down on disable.
`timescale 1ns/1ps
module pid_pwm_actuator #(
   parameter int DATA_W    = 8,
   parameter int SLEW_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   output logic              pwm_out,
   output logic [DATA_W-1:0] duty_active,
   output logic              period_start,
   output logic              at_target,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, RUN, RAMP_DOWN} state_t;

   localparam logic [DATA_W:0]   STEP    = (DATA_W+1)'(SLEW_STEP);
   localparam logic [DATA_W-1:0] CNT_MAX = {DATA_W{1'b1}};
   localparam logic [DATA_W-1:0] CNT_ONE = DATA_W'(1);

   state_t            state, state_nx;
   logic [DATA_W-1:0] cnt, cnt_nx;
   logic [DATA_W-1:0] pend, pend_nx;
   logic              pend_valid, pend_valid_nx;
   logic [DATA_W-1:0] target, target_nx;
   logic [DATA_W-1:0] duty_nx;
   logic [DATA_W-1:0] slew_tgt;
   logic              boundary;

   // Step up by at most STEP, clamped at tgt; the extra bit keeps the sum from wrapping.
   function automatic logic [DATA_W-1:0] slew_up(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] tgt);
      logic [DATA_W:0] sum;
      sum = {1'b0, cur} + STEP;
      return (sum > {1'b0, tgt}) ? tgt : sum[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] slew_down(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] floor);
      logic signed [DATA_W+1:0] diff;
      diff = $signed({2'b00, cur}) - $signed({1'b0, STEP});
      return (diff < $signed({2'b00, floor})) ? floor : diff[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] cur,
                                              input logic [DATA_W-1:0] tgt);
      if (tgt > cur)      return slew_up(cur, tgt);
      else if (tgt < cur) return slew_down(cur, tgt);
      else                return cur;
   endfunction

   assign cmd_ready = !pend_valid;
   assign at_target = (duty_active == target);
   assign busy      = (state != IDLE);
   assign boundary  = (state != IDLE) && (cnt == CNT_MAX);

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      target_nx     = target;
      duty_nx       = duty_active;
      pend_nx       = pend;
      pend_valid_nx = pend_valid;
      slew_tgt      = target;
      if (cmd_valid && cmd_ready) begin
         pend_nx       = cmd_data;
         pend_valid_nx = 1'b1;
      end
      case (state)
         IDLE: begin
            cnt_nx  = '0;
            duty_nx = '0;
            if (enable) state_nx = RUN;
         end
         default: begin
            cnt_nx = cnt + CNT_ONE;
            if (enable) begin
               // Re-enable during ramp-down resumes slewing from the current duty.
               state_nx = RUN;
               if (boundary) begin
                  if (pend_valid) begin
                     slew_tgt      = pend;
                     target_nx     = pend;
                     pend_valid_nx = 1'b0;
                  end
                  duty_nx = slew(duty_active, slew_tgt);
               end
            end else if (state == RUN) begin
               state_nx = RAMP_DOWN;
            end else if (boundary) begin
               if (duty_active == '0) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else begin
                  duty_nx = slew_down(duty_active, '0);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         pend         <= '0;
         pend_valid   <= 1'b0;
         target       <= '0;
         duty_active  <= '0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         pend         <= pend_nx;
         pend_valid   <= pend_valid_nx;
         target       <= target_nx;
         duty_active  <= duty_nx;
         // Output stage: compare against next-cycle values so pwm_out lines up with cnt.
         pwm_out      <= (state_nx != IDLE) && (cnt_nx < duty_nx);
         period_start <= (state_nx != IDLE) && (cnt_nx == '0);
      end
   end

endmodule

// File: tb/tb_pid_pwm_actuator.sv
// Self-checking bench for pid_pwm_actuator: table of slew commands plus
// back-pressure, disable ramp and mid-period reset sequences.
`timescale 1ns/1ps
module tb_pid_pwm_actuator;

   localparam int DATA_W = 8;
   localparam int SLEW   = 4;

   logic              clk = 1'b0;
   logic              rst, enable, cmd_valid;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_ready, pwm_out, period_start, at_target, busy;
   logic [DATA_W-1:0] duty_active;

   always #5 clk = ~clk;

   pid_pwm_actuator #(.DATA_W(DATA_W), .SLEW_STEP(SLEW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .cmd_data(cmd_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .pwm_out(pwm_out),
      .duty_active(duty_active), .period_start(period_start),
      .at_target(at_target), .busy(busy)
   );

   typedef struct packed {
      logic [7:0] cmd;
      logic [7:0] steps;
      logic [7:0] fin_duty;
      logic       chk_low;
   } vec_t;

   vec_t vecs[6];
   int   exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   model_duty = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tmo(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out, got no event, expected one (t=%0t)", name, $time);
   endtask

   // Scoreboard: pop expected duty at each period start; check the previous period's high count.
   initial begin : monitor
      int hi_cnt;
      int prev_exp;
      hi_cnt   = 0;
      prev_exp = -1;
      forever begin
         @(negedge clk);
         if (busy !== 1'b1) begin
            hi_cnt   = 0;
            prev_exp = -1;
         end else if (period_start === 1'b1) begin
            if (prev_exp >= 0) check("pwm_high_count", hi_cnt, prev_exp);
            prev_exp = -1;
            if (exp_q.size() > 0) begin
               prev_exp = exp_q.pop_front();
               check("sb_duty", int'(duty_active), prev_exp);
            end
            hi_cnt = (pwm_out === 1'b1) ? 1 : 0;
         end else begin
            hi_cnt += (pwm_out === 1'b1) ? 1 : 0;
         end
      end
   end

   task automatic push_slew(input int tgt);
      while (model_duty != tgt) begin
         if (tgt > model_duty) model_duty = (model_duty + SLEW > tgt) ? tgt : model_duty + SLEW;
         else                  model_duty = (model_duty - SLEW < tgt) ? tgt : model_duty - SLEW;
         exp_q.push_back(model_duty);
      end
   endtask

   task automatic wait_ps(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (period_start !== 1'b1 && n < budget);
      if (period_start !== 1'b1) tmo("wait_period_start");
   endtask

   task automatic send(input logic [7:0] v);
      int n = 0;
      cmd_data  = v;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (cmd_ready !== 1'b1) tmo("send_ready");
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run_to_target(input string name, input int steps, input int fin);
      int k = 0;
      int n = 0;
      int budget;
      budget = (steps + 3) * 260;
      do begin
         @(negedge clk);
         n++;
         if (period_start === 1'b1) k++;
      end while (!(period_start === 1'b1 && at_target === 1'b1) && n < budget);
      if (!(period_start === 1'b1 && at_target === 1'b1)) tmo(name);
      else begin
         check({name, "_steps"}, k, steps);
         check({name, "_duty"}, int'(duty_active), fin);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      int lows;
      wait_ps(300);
      repeat (3) @(negedge clk);
      send(v.cmd);
      push_slew(int'(v.cmd));
      run_to_target("vec", int'(v.steps), int'(v.fin_duty));
      if (v.chk_low) begin
         wait_ps(300);
         lows = 0;
         for (int i = 0; i < 256; i++) begin
            lows += (pwm_out === 1'b0) ? 1 : 0;
            @(negedge clk);
         end
         check("full_duty_low_cycles", lows, 1);
      end
   endtask

   initial begin : main
      int n;
      int bad;
      vec_t v;
      rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
      vecs[0] = '{8'h10, 8'd4,  8'h10, 1'b0};
      vecs[1] = '{8'h0A, 8'd2,  8'h0A, 1'b0};
      vecs[2] = '{8'hFC, 8'd61, 8'hFC, 1'b0};
      vecs[3] = '{8'hFF, 8'd1,  8'hFF, 1'b1};
      vecs[4] = '{8'h02, 8'd64, 8'h02, 1'b0};
      vecs[5] = '{8'h00, 8'd1,  8'h00, 1'b0};

      // Reset and idle
      repeat (2) @(negedge clk);
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_duty", int'(duty_active), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_at_target", int'(at_target), 1);
      check("rst_period_start", int'(period_start), 0);
      rst = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (pwm_out !== 1'b0 || period_start !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("idle_quiet", bad, 0);

      // Slew table
      enable = 1'b1;
      model_duty = 0;
      for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

      // Back-pressure: 0x20 then 0x40 held until the holding register frees
      wait_ps(300);
      repeat (3) @(negedge clk);
      send(8'h20);
      model_duty = SLEW;
      exp_q.push_back(SLEW);
      check("bp_ready_low", int'(cmd_ready), 0);
      cmd_data  = 8'h40;
      cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("bp_wait_cycles", n, 252);
      check("bp_ready_at_period_start", int'(period_start), 1);
      check("bp_first_step", int'(duty_active), SLEW);
      check("bp_not_at_target", int'(at_target), 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("bp_second_taken", int'(cmd_ready), 0);
      push_slew(8'h40);
      run_to_target("bp", 15, 8'h40);

      // Disable ramp from 0x0C with a command left pending
      v = '{8'h0C, 8'd13, 8'h0C, 1'b0};
      apply_vec(v);
      wait_ps(300);
      repeat (10) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("ramp_busy", int'(busy), 1);
      send(8'h80);
      while (model_duty > 0) begin
         model_duty = (model_duty > SLEW) ? model_duty - SLEW : 0;
         exp_q.push_back(model_duty);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(period_start === 1'b1 && duty_active == '0) && n < 1100);
      if (!(period_start === 1'b1 && duty_active == '0)) tmo("ramp_zero");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy === 1'b1 && n < 400);
      check("ramp_idle_delay", n, 256);
      check("ramp_pwm", int'(pwm_out), 0);
      check("ramp_pend_kept", int'(cmd_ready), 0);
      check("ramp_duty", int'(duty_active), 0);
      check("ramp_at_target", int'(at_target), 0);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (pwm_out !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("ramp_idle_quiet", bad, 0);

      // Re-enable, then reset mid-period with pwm high and a command pending
      enable = 1'b1;
      wait_ps(10);
      check("rerun_duty_zero", int'(duty_active), 0);
      model_duty = SLEW;
      exp_q.push_back(SLEW);
      wait_ps(300);
      check("rerun_pend_applied", int'(cmd_ready), 1);
      cmd_data  = 8'h30;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("pre_rst_pwm", int'(pwm_out), 1);
      check("pre_rst_pend", int'(cmd_ready), 0);
      rst    = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("mid_rst_pwm", int'(pwm_out), 0);
      check("mid_rst_ready", int'(cmd_ready), 1);
      check("mid_rst_duty", int'(duty_active), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_period_start", int'(period_start), 0);
      check("mid_rst_at_target", int'(at_target), 1);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_busy", int'(busy), 0);
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
